// File: rtl/product_accumulator.sv
// product_accumulator: sums TERMS shifted partial products into a WIDTH-bit
// product register, tracking the term index for the upstream nibble shifter.
module product_accumulator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TERMS = 4
) (
    input  logic                     clk,
    input  logic                     reset_a,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pp_in,
    input  logic                     pp_valid,
    output logic [$clog2(TERMS)-1:0] term_idx,
    output logic [WIDTH-1:0]         product,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int unsigned IDX_W = $clog2(TERMS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   term_idx_next;
    logic [WIDTH-1:0]   product_next;
    logic               overflow_next;
    logic               busy_next;
    logic               done_next;
    logic [WIDTH:0]     sum_c;

    // Full-width add; the top bit is the carry out of WIDTH.
    assign sum_c = {1'b0, product} + {1'b0, pp_in};

    // State and datapath registers; busy/done registered from the next state.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state    <= IDLE;
            term_idx <= '0;
            product  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            term_idx <= term_idx_next;
            product  <= product_next;
            overflow <= overflow_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // Next-state and datapath update; start always wins over pp_valid.
    always_comb begin
        state_next    = state;
        term_idx_next = term_idx;
        product_next  = product;
        overflow_next = overflow;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = ACCUM;
                    term_idx_next = '0;
                    product_next  = '0;
                    overflow_next = 1'b0;
                end
            end
            ACCUM: begin
                if (start) begin
                    term_idx_next = '0;
                    product_next  = '0;
                    overflow_next = 1'b0;
                end else if (pp_valid) begin
                    product_next  = sum_c[WIDTH-1:0];
                    overflow_next = overflow | sum_c[WIDTH];
                    if (term_idx == IDX_W'(TERMS - 1)) begin
                        term_idx_next = '0;
                        state_next    = DONE;
                    end else begin
                        term_idx_next = IDX_W'(term_idx + 1'b1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == ACCUM);
        done_next = (state_next == DONE);
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the nibble shifter in the 8x8 sequential multiplier datapath. It sums TERMS shifted partial products, one per accepted cycle, into a WIDTH-bit product register. A small FSM tracks the term index for upstream nibble-select and shift control, and flags completion. The block replaces the loose adder + register + counter glue with one verified sequential unit.

## Interface
- WIDTH, 16: accumulator and partial-product width.
- TERMS, 4: partial products per multiplication; must be ≥2. term_idx width is clog2(TERMS).

- clk  in  1  rising-edge clock.
- reset_a  in  1  asynchronous, active-low reset.
- start  in  1  begin a new multiplication: clear the accumulator and the term index.
- pp_in  in  WIDTH  shifted partial product from the shifter.
- pp_valid  in  1  pp_in is valid this cycle.
- term_idx  out  clog2(TERMS)  index of the term expected next. Upstream derives nibble select and shift_cntrl from it.
- product  out  WIDTH  accumulated sum.
- busy  out  1  high in ACCUM.
- done  out  1  high in DONE; product is final.
- overflow  out  1  sticky; set if any addition carries out of WIDTH.

## Operation
- Reset (reset_a low, asynchronous): state=IDLE, product=0, term_idx=0, busy=0, done=0, overflow=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - pp_valid is ignored.
  - start=1 -> ACCUM, with product=0, term_idx=0, overflow=0.
- ACCUM:
  - start=1 takes priority over pp_valid: restart (product=0, term_idx=0, overflow=0, stay in ACCUM). The pp_in of that cycle is discarded.
  - Otherwise, pp_valid=1: {carry, product} <= product + pp_in; overflow <= overflow | carry.
  - If term_idx = TERMS-1: go to DONE, term_idx <= 0. Otherwise term_idx <= term_idx+1.
  - pp_valid=0: hold everything. Gaps of any length are allowed.
- DONE:
  - product, overflow and done hold; pp_valid is ignored.
  - start=1 -> ACCUM with a cleared accumulator, same as from IDLE.
  - DONE never returns to IDLE on its own.
- Arithmetic: unsigned, modulo 2^WIDTH. With WIDTH=16 and 8x8 operands, overflow never sets in normal use; it exists for verification and reuse.
- term_idx is a registered output that changes only on accepted terms, restart or reset.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- start sampled at edge k -> after edge k: busy=1, product=0, term_idx=0.
- With pp_valid held high from cycle k+1:
  - terms are accepted at edges k+1..k+TERMS;
  - done=1 and busy=0 after edge k+TERMS (4 cycles after start for TERMS=4).
- Each pp_valid gap cycle adds exactly one cycle of latency.
- done and busy are mutually exclusive; both are 0 only in IDLE.
- Reset asserted mid-operation clears all state immediately, without waiting for clk. The first start after reset release behaves as from IDLE.
- Throughput: back-to-back multiplications are possible by asserting start in the first DONE cycle, giving TERMS+1 cycles per product.

## Test plan
- Reset values: hold reset_a low, toggle pp_valid and start -> product=0, term_idx=0, busy=0, done=0, overflow=0 throughout.
- 0xFF×0xFF: start, then pp_in = 225, 3600, 3600, 57600 on consecutive cycles with pp_valid=1:
  - term_idx steps 0,1,2,3 then 0;
  - done rises 4 cycles after start with product=0xFE01 (65025) and overflow=0.
- Gapped valid: same four terms with pp_valid=0 for 2 cycles between terms 1 and 2 -> product=0xFE01, done 6 cycles after start, term_idx held at 2 during the gap.
- Overflow: four terms of 0xFFFF -> product=0xFFFC, overflow=1. A following start clears overflow to 0.
- Restart and reset:
  - start after 2 accepted terms -> product=0, term_idx=0; the next four terms sum fresh (e.g. 1,2,3,4 -> product=10).
  - reset_a pulsed low between clock edges mid-ACCUM -> outputs zero at once, state IDLE.
- DONE hold: in DONE, drive pp_valid=1 with pp_in=0x1234 for 3 cycles -> product and done unchanged. Then start -> busy=1, done=0, product=0.
